ntt_io_sequencer: RTL and testbench
===================================

# ntt_io_sequencer

- Job-level sequencer that sits upstream and downstream of the NTT controller.
- Streams one polynomial into the 257 coefficient banks, starts the controller with the latched modulus index, waits for completion, then streams the result back out with backpressure.
- Owns the memory port only while the controller is idle; the top level muxes bank address/write-enable between this block and the controller using `mem_own`.

## Interface
Parameters:
- `COEFF_W`, 64, coefficient width.
- `N_BANKS`, 257, number of coefficient banks.
- `DEPTH`, 256, words per bank (address width `$clog2(DEPTH)`).
- `READ_LATENCY`, 1, bank read latency in cycles (≥1).

Ports:
- `clk`, in, 1, clock.
- `reset`, in, 1, reset, synchronous, active-high.
- `job_start`, in, 1, pulse in IDLE begins a job; ignored otherwise.
- `job_mod_idx`, in, 6, modulus index, latched on accepted `job_start`.
- `in_valid` in 1, `in_ready` out 1, `in_data` in COEFF_W: input coefficient stream.
- `out_valid` out 1, `out_ready` in 1, `out_data` out COEFF_W, `out_last` out 1: output coefficient stream.
- `mem_own`, out, 1, high when this block drives the bank port.
- `mem_bank`, out, 9, target bank index.
- `mem_addr`, out, 8, bank word address.
- `mem_we`, out, 1, write strobe to `mem_bank`.
- `mem_wdata`, out, COEFF_W, write data.
- `mem_rdata`, in, COEFF_W, read data of `mem_bank`/`mem_addr`, valid READ_LATENCY cycles after issue.
- `ctrl_start`, out, 1, one-cycle start pulse to the controller.
- `ctrl_mod_idx`, out, 6, latched modulus index; held for the whole job.
- `ctrl_done`, in, 1, controller idle indication (high whenever the controller is idle).
- `busy`, out, 1, high in every state except IDLE.
- `job_done`, out, 1, one-cycle pulse after the last output word handshakes.

## Operation
- **States:** IDLE, LOAD, KICK, WAIT_BUSY, WAIT_DONE, UNLOAD.
- **Address order:** bank counter is the inner loop (0..N_BANKS-1), address counter the outer loop (0..DEPTH-1). Both wrap to 0 at the end of each phase. Each phase moves N_BANKS·DEPTH words.
- **IDLE:**
  - `in_ready`=0, `mem_own`=0.
  - `job_start` latches `job_mod_idx`, clears both counters and moves to LOAD.
- **LOAD:**
  - `mem_own`=1, `in_ready`=1.
  - Each `in_valid` beat drives `mem_we`=1 with `mem_wdata`=`in_data` at the current bank/address (combinational from the counters), then advances the counters.
  - The final beat (bank N_BANKS-1, address DEPTH-1) moves to KICK.
- **KICK:** `mem_own`=0, `ctrl_start`=1 for exactly one cycle, then WAIT_BUSY.
- **WAIT_BUSY:** waits for `ctrl_done`=0, then WAIT_DONE. This guards against the controller's idle level, which is still high in the KICK cycle.
- **WAIT_DONE:** waits for `ctrl_done`=1, then UNLOAD with counters cleared.
- **UNLOAD:**
  - `mem_own`=1.
  - Read issue is gated by credits: issue only when FIFO occupancy plus reads in flight is less than FIFO_DEPTH (= READ_LATENCY+2). `mem_rdata` is pushed into the skid FIFO READ_LATENCY cycles after issue.
  - `out_valid` = FIFO not empty. `out_last` is set on the FIFO entry of the final word.
  - When the `out_last` word handshakes: pulse `job_done`, go to IDLE.
- **Flow control:** `in_valid`/`out_ready` may toggle every cycle. No word is dropped or duplicated.

## Timing
- **Reset values:** every output is 0 (`in_ready`, `out_valid`, `out_last`, `mem_*`, `ctrl_start`, `ctrl_mod_idx`, `busy`, `job_done`); state is IDLE; FIFO and credit count are empty.
- **Reset mid-job:** the job is abandoned with no further `mem_we`, and the next cycle matches the reset values.
- **Load:** 1 word/cycle at full `in_valid`. `mem_we` is in the same cycle as the handshake.
- **Start:** `ctrl_start` is asserted the cycle after the final load beat.
- **First output:** the first read issues in the first UNLOAD cycle; the first `out_valid` rises READ_LATENCY+1 cycles later.
- **Throughput:** sustained 1 word/cycle with `out_ready`=1.
- **Backpressure:** `out_data`/`out_last` stay stable while `out_valid`=1 and `out_ready`=0.
- **Stray/overlapping events:**
  - `job_start` while `busy`=1 is ignored.
  - `ctrl_done` edges outside WAIT_BUSY/WAIT_DONE are ignored.

## Structure
- **Shared package:** state enum, N_BANKS/DEPTH defaults, and the FIFO_DEPTH derivation. These are shared with the controller top so the bank geometry has a single source.
- **Sub-module:** `io_skid_fifo` (parameters COEFF_W+1 width and FIFO_DEPTH). It is a registered-output FIFO with a count output, used for the unload path.

## Test plan
Benches run with N_BANKS=3, DEPTH=4, READ_LATENCY=2 plus one full-size smoke run.
- **Basic load:** `job_start`, mod_idx=5, 12 words 0..11 with `in_valid` held high → writes (bank,addr) (0,0),(1,0),(2,0),(0,1)…(2,3). Then one `ctrl_start` pulse with `ctrl_mod_idx`=5.
- **Controller handshake:** model keeps `ctrl_done` high 1 cycle after the start pulse, then low 10 cycles, then high → UNLOAD entered only after the rise. Exactly 12 outputs in load order, `out_last` on the 12th, `job_done` pulse after it.
- **Backpressure:** `out_ready` random 30% low → output sequence unchanged, `out_data` stable while stalled, never more than FIFO_DEPTH reads outstanding.
- **Input bubbles:** `in_valid` alternating 1/0 → 12 writes, no duplicates, `in_ready` high throughout LOAD.
- **Reset during UNLOAD** (after 5 outputs) → next cycle all outputs 0, state IDLE. A new job then completes correctly.
- **Ignored start:** `job_start` asserted during WAIT_DONE → ignored. `ctrl_mod_idx` unchanged, no second `ctrl_start`.

Source files
------------

// File: rtl/ntt_io_sequencer_pkg.sv
// Shared definitions for the NTT job sequencer: bank geometry defaults, state codes
// and the skid FIFO sizing rule (also used by the controller top).
package ntt_io_sequencer_pkg;

    localparam int unsigned N_BANKS_DEF = 257;
    localparam int unsigned DEPTH_DEF   = 256;
    localparam int unsigned BANK_W      = 9;
    localparam int unsigned ADDR_W      = 8;
    localparam int unsigned MOD_W       = 6;
    localparam int unsigned STATE_W     = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_LOAD      = 3'd1;
    localparam state_t S_KICK      = 3'd2;
    localparam state_t S_WAIT_BUSY = 3'd3;
    localparam state_t S_WAIT_DONE = 3'd4;
    localparam state_t S_UNLOAD    = 3'd5;

    // Reads in flight plus two entries of slack keep the output at one word per cycle.
    function automatic int unsigned fifo_depth(input int unsigned read_latency);
        return read_latency + 2;
    endfunction

endpackage

// File: rtl/io_skid_fifo.sv
// Small registered-output FIFO with an occupancy count, used on the unload read path.
module io_skid_fifo #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic                         valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr] <= din;
        end
    end

    assign valid = (cnt != '0);
    assign dout  = valid ? mem_q[rd_ptr] : '0;
    assign count = cnt;

endmodule

// File: rtl/ntt_io_sequencer.sv
// Job sequencer around the NTT controller: loads one polynomial into the banks, kicks
// the controller, waits for it to finish, then streams the result out with backpressure.
module ntt_io_sequencer
    import ntt_io_sequencer_pkg::*;
#(
    parameter int unsigned COEFF_W      = 64,
    parameter int unsigned N_BANKS      = N_BANKS_DEF,
    parameter int unsigned DEPTH        = DEPTH_DEF,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               job_start,
    input  logic [5:0]         job_mod_idx,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COEFF_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COEFF_W-1:0] out_data,
    output logic               out_last,
    output logic               mem_own,
    output logic [8:0]         mem_bank,
    output logic [7:0]         mem_addr,
    output logic               mem_we,
    output logic [COEFF_W-1:0] mem_wdata,
    input  logic [COEFF_W-1:0] mem_rdata,
    output logic               ctrl_start,
    output logic [5:0]         ctrl_mod_idx,
    input  logic               ctrl_done,
    output logic               busy,
    output logic               job_done
);

    localparam int unsigned FIFO_DEPTH = fifo_depth(READ_LATENCY);
    localparam int unsigned FIFO_W     = COEFF_W + 1;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [BANK_W-1:0] LAST_BANK  = BANK_W'(N_BANKS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W:0]    FIFO_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);

    state_t                  state;
    state_t                  state_nx;
    logic [BANK_W-1:0]       bank_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [MOD_W-1:0]        mod_idx_q;
    logic                    issue_done_q;
    logic [READ_LATENCY-1:0] rd_vld_pipe;
    logic [READ_LATENCY-1:0] rd_last_pipe;
    logic [CNT_W-1:0]        inflight_q;
    logic                    job_done_q;

    logic                    at_last;
    logic                    clr_cnt;
    logic                    issue;
    logic                    advance;
    logic                    push;
    logic                    pop;
    logic                    out_hs_last;
    logic [FIFO_W-1:0]       fifo_dout;
    logic                    fifo_valid;
    logic [CNT_W-1:0]        fifo_count;
    logic [CNT_W:0]          credits_used;

    assign at_last      = (bank_q == LAST_BANK) && (addr_q == LAST_ADDR);
    assign credits_used = {1'b0, fifo_count} + {1'b0, inflight_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state plus the decoded per-state strobes
    always_comb begin
        state_nx   = state;
        in_ready   = 1'b0;
        mem_own    = 1'b0;
        mem_we     = 1'b0;
        ctrl_start = 1'b0;
        issue      = 1'b0;
        clr_cnt    = 1'b0;
        case (state)
            S_IDLE: begin
                if (job_start) begin
                    state_nx = S_LOAD;
                    clr_cnt  = 1'b1;
                end
            end
            S_LOAD: begin
                mem_own  = 1'b1;
                in_ready = 1'b1;
                mem_we   = in_valid && !reset;
                if (in_valid && at_last) begin
                    state_nx = S_KICK;
                end
            end
            S_KICK: begin
                ctrl_start = 1'b1;
                state_nx   = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // The controller's idle level is still high right after the kick.
                if (!ctrl_done) begin
                    state_nx = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (ctrl_done) begin
                    state_nx = S_UNLOAD;
                    clr_cnt  = 1'b1;
                end
            end
            S_UNLOAD: begin
                mem_own = 1'b1;
                issue   = !issue_done_q && (credits_used < FIFO_LIMIT);
                if (out_hs_last) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign advance = mem_we || issue;

    // Bank is the inner loop, address the outer; both wrap after the last word
    always_ff @(posedge clk) begin
        if (reset || clr_cnt) begin
            bank_q <= '0;
            addr_q <= '0;
        end else if (advance) begin
            if (bank_q == LAST_BANK) begin
                bank_q <= '0;
                addr_q <= (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
            end else begin
                bank_q <= bank_q + BANK_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr_cnt) begin
            issue_done_q <= 1'b0;
        end else if (issue && at_last) begin
            issue_done_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mod_idx_q <= '0;
        end else if ((state == S_IDLE) && job_start) begin
            mod_idx_q <= job_mod_idx;
        end
    end

    // Read-return tracking: a valid/last tag per outstanding read
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld_pipe  <= '0;
            rd_last_pipe <= '0;
        end else begin
            rd_vld_pipe[0]  <= issue;
            rd_last_pipe[0] <= issue && at_last;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                rd_vld_pipe[i]  <= rd_vld_pipe[i-1];
                rd_last_pipe[i] <= rd_last_pipe[i-1];
            end
        end
    end

    assign push = rd_vld_pipe[READ_LATENCY-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q <= '0;
        end else begin
            case ({issue, push})
                2'b10:   inflight_q <= inflight_q + CNT_W'(1);
                2'b01:   inflight_q <= inflight_q - CNT_W'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    io_skid_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_skid_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   ({rd_last_pipe[READ_LATENCY-1], mem_rdata}),
        .pop   (pop),
        .dout  (fifo_dout),
        .valid (fifo_valid),
        .count (fifo_count)
    );

    assign out_valid   = fifo_valid;
    assign out_data    = fifo_dout[COEFF_W-1:0];
    assign out_last    = fifo_dout[COEFF_W];
    assign pop         = fifo_valid && out_ready;
    assign out_hs_last = pop && out_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            job_done_q <= 1'b0;
        end else begin
            job_done_q <= out_hs_last;
        end
    end

    assign mem_bank     = mem_own ? bank_q : '0;
    assign mem_addr     = mem_own ? addr_q : '0;
    assign mem_wdata    = mem_we ? in_data : '0;
    assign ctrl_mod_idx = mod_idx_q;
    assign busy         = (state != S_IDLE);
    assign job_done     = job_done_q;

endmodule

// File: tb/tb_ntt_io_sequencer.sv
// Randomized scoreboard bench for ntt_io_sequencer on a 3-bank x 4-word geometry.
module tb_ntt_io_sequencer;

    localparam int unsigned COEFF_W      = 64;
    localparam int unsigned N_BANKS      = 3;
    localparam int unsigned DEPTH        = 4;
    localparam int unsigned READ_LATENCY = 2;
    localparam int unsigned NWORDS       = N_BANKS * DEPTH;

    typedef struct packed {
        logic [8:0]         bank;
        logic [7:0]         addr;
        logic [COEFF_W-1:0] data;
    } wr_t;

    typedef struct packed {
        logic               last;
        logic [COEFF_W-1:0] data;
    } out_t;

    logic               clk;
    logic               reset;
    logic               job_start;
    logic [5:0]         job_mod_idx;
    logic               in_valid;
    logic               in_ready;
    logic [COEFF_W-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [COEFF_W-1:0] out_data;
    logic               out_last;
    logic               mem_own;
    logic [8:0]         mem_bank;
    logic [7:0]         mem_addr;
    logic               mem_we;
    logic [COEFF_W-1:0] mem_wdata;
    logic [COEFF_W-1:0] mem_rdata;
    logic               ctrl_start;
    logic [5:0]         ctrl_mod_idx;
    logic               ctrl_done;
    logic               busy;
    logic               job_done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    wr_t  wr_exp[$];
    out_t out_exp[$];

    logic [COEFF_W-1:0] mem_model [N_BANKS][DEPTH];
    logic [COEFF_W-1:0] rd_s0;
    logic [COEFF_W-1:0] rd_s1;

    bit         in_reset;
    bit         glitch_en;
    int         stall_pct;
    logic [5:0] job_mod;
    int         starts_this_job;
    int         outs_this_job;
    int         ctrl_low_cnt;
    bit         ctrl_low;
    int         rise_cyc;
    bit         rise_valid;
    bit         seen_first;
    int         first_out_cyc;
    int         last_hs_cyc;
    int         last_wr_cyc;
    bit         jd_pending;
    int         jd_cyc;
    bit         job_complete;

    ntt_io_sequencer #(
        .COEFF_W      (COEFF_W),
        .N_BANKS      (N_BANKS),
        .DEPTH        (DEPTH),
        .READ_LATENCY (READ_LATENCY)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .job_start    (job_start),
        .job_mod_idx  (job_mod_idx),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .mem_own      (mem_own),
        .mem_bank     (mem_bank),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .ctrl_start   (ctrl_start),
        .ctrl_mod_idx (ctrl_mod_idx),
        .ctrl_done    (ctrl_done),
        .busy         (busy),
        .job_done     (job_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bank memory: write on the edge, read data returns READ_LATENCY cycles after the address
    always @(posedge clk) begin
        if (mem_we && (mem_bank < 9'(N_BANKS)) && (mem_addr < 8'(DEPTH)))
            mem_model[mem_bank][mem_addr] <= mem_wdata;
        if ((mem_bank < 9'(N_BANKS)) && (mem_addr < 8'(DEPTH)))
            rd_s0 <= mem_model[mem_bank][mem_addr];
        else
            rd_s0 <= '0;
        rd_s1 <= rd_s0;
    end
    assign mem_rdata = rd_s1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"},     64'(in_ready), 64'd0);
        chk({tag, "_out_valid"},    64'(out_valid), 64'd0);
        chk({tag, "_out_last"},     64'(out_last), 64'd0);
        chk({tag, "_out_data"},     out_data, 64'd0);
        chk({tag, "_mem_own"},      64'(mem_own), 64'd0);
        chk({tag, "_mem_bank"},     64'(mem_bank), 64'd0);
        chk({tag, "_mem_addr"},     64'(mem_addr), 64'd0);
        chk({tag, "_mem_we"},       64'(mem_we), 64'd0);
        chk({tag, "_mem_wdata"},    mem_wdata, 64'd0);
        chk({tag, "_ctrl_start"},   64'(ctrl_start), 64'd0);
        chk({tag, "_ctrl_mod_idx"}, 64'(ctrl_mod_idx), 64'd0);
        chk({tag, "_busy"},         64'(busy), 64'd0);
        chk({tag, "_job_done"},     64'(job_done), 64'd0);
    endtask

    // Controller model: idle high, stays high one cycle after start, low 10 cycles, then high
    initial begin : ctrl_model
        int cnt;
        cnt       = 0;
        ctrl_done = 1'b1;
        forever begin
            @(negedge clk);
            if (in_reset) begin
                cnt = 0; ctrl_done = 1'b1; ctrl_low = 1'b0;
            end else if (cnt == 0) begin
                ctrl_done = glitch_en ? 1'($urandom_range(0, 1)) : 1'b1;
            end else if (cnt == 1) begin
                ctrl_done = 1'b1; cnt = 2;
            end else if (cnt < 12) begin
                ctrl_done = 1'b0; ctrl_low = 1'b1; ctrl_low_cnt++; cnt++;
            end else begin
                ctrl_done = 1'b1; ctrl_low = 1'b0; cnt = 0;
                rise_cyc = cyc; rise_valid = 1'b1;
            end
            #2;
            if (!in_reset) begin
                if (ctrl_low) chk("mem_own_while_ctrl_busy", 64'(mem_own), 64'd0);
                if (ctrl_start) begin
                    starts_this_job++;
                    chk("ctrl_mod_idx_at_start", 64'(ctrl_mod_idx), 64'(job_mod));
                    chk("ctrl_start_timing", 64'(cyc), 64'(last_wr_cyc + 1));
                    if (cnt == 0) cnt = 1;
                end
            end
        end
    end

    initial begin : ready_driver
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 99) >= stall_pct);
        end
    end

    initial begin : write_monitor
        wr_t w;
        forever begin
            @(negedge clk); #2;
            if (!in_reset && mem_we) begin
                chk("write_owns_port", 64'(mem_own), 64'd1);
                if (wr_exp.size() == 0) begin
                    chk("write_unexpected", 64'd1, 64'd0);
                end else begin
                    w = wr_exp.pop_front();
                    chk("write_bank",  64'(mem_bank), 64'(w.bank));
                    chk("write_addr",  64'(mem_addr), 64'(w.addr));
                    chk("write_data",  mem_wdata, w.data);
                end
                last_wr_cyc = cyc;
            end
        end
    end

    initial begin : output_monitor
        out_t               e;
        bit                 prev_stall;
        logic [COEFF_W-1:0] prev_data;
        logic               prev_last;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk); #2;
            if (in_reset) begin
                prev_stall = 1'b0;
            end else begin
                if (out_valid && !seen_first) begin
                    seen_first    = 1'b1;
                    first_out_cyc = cyc;
                    if (rise_valid)
                        chk("first_out_latency", 64'(cyc), 64'(rise_cyc + int'(READ_LATENCY) + 2));
                end
                if (prev_stall) begin
                    chk("stall_valid", 64'(out_valid), 64'd1);
                    chk("stall_data",  out_data, prev_data);
                    chk("stall_last",  64'(out_last), 64'(prev_last));
                end
                if (out_valid && out_ready) begin
                    if (out_exp.size() == 0) begin
                        chk("out_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = out_exp.pop_front();
                        chk("out_data", out_data, e.data);
                        chk("out_last", 64'(out_last), 64'(e.last));
                    end
                    outs_this_job++;
                    last_hs_cyc = cyc;
                    if (out_last) begin
                        jd_pending = 1'b1;
                        jd_cyc     = cyc + 1;
                    end
                end
                if (jd_pending && cyc == jd_cyc) begin
                    chk("job_done_pulse", 64'(job_done), 64'd1);
                    chk("busy_after_done", 64'(busy), 64'd0);
                    jd_pending   = 1'b0;
                    job_complete = 1'b1;
                end else if (job_done) begin
                    chk("job_done_stray", 64'd1, 64'd0);
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_last  = out_last;
            end
        end
    end

    task automatic mid_reset();
        @(negedge clk);
        in_reset = 1'b1;
        reset    = 1'b1;
        in_valid = 1'b0;
        job_start = 1'b0;
        @(posedge clk); #2;
        check_idle("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        out_exp.delete();
        wr_exp.delete();
        jd_pending = 1'b0;
        @(posedge clk); #1;
        in_reset = 1'b0;
    endtask

    // bubble: 0 = in_valid held, 1 = alternating, 2 = random
    task automatic run_job(input logic [5:0] mod, input int bubble, input int stall,
                           input bit stray, input int reset_after, input bit glitch, input bit seq);
        int                 k;
        int                 guard;
        bit                 v;
        logic [COEFF_W-1:0] d;
        wr_t                w;
        out_t               o;
        stall_pct       = stall;
        job_mod         = mod;
        starts_this_job = 0;
        outs_this_job   = 0;
        ctrl_low_cnt    = 0;
        seen_first      = 1'b0;
        rise_valid      = 1'b0;
        job_complete    = 1'b0;
        @(negedge clk);
        job_start   = 1'b1;
        job_mod_idx = mod;
        k = 0;
        guard = 0;
        while (k < int'(NWORDS) && guard < 200) begin
            @(negedge clk);
            job_start   = 1'b0;
            job_mod_idx = 6'($urandom);
            guard++;
            glitch_en = glitch && (k < int'(NWORDS) - 1);
            case (bubble)
                0:       v = 1'b1;
                1:       v = (guard % 2) == 1;
                default: v = 1'($urandom_range(0, 1));
            endcase
            d = seq ? 64'(k) : {$urandom, $urandom};
            in_valid = v;
            in_data  = v ? d : {$urandom, $urandom};
            #1;
            chk("in_ready_in_load", 64'(in_ready), 64'd1);
            if (v && in_ready) begin
                w.bank = 9'(k % int'(N_BANKS));
                w.addr = 8'(k / int'(N_BANKS));
                w.data = d;
                wr_exp.push_back(w);
                o.data = d;
                o.last = (k == int'(NWORDS) - 1);
                out_exp.push_back(o);
                k++;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        glitch_en = 1'b0;
        if (k < int'(NWORDS)) chk("load_timeout", 64'(k), 64'(NWORDS));
        if (stray) begin
            guard = 0;
            while (ctrl_low_cnt < 3 && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            job_start   = 1'b1;
            job_mod_idx = mod ^ 6'h15;
            @(negedge clk);
            job_start = 1'b0;
        end
        guard = 0;
        while (!job_complete && !(reset_after > 0 && outs_this_job >= reset_after) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (reset_after > 0) begin
            chk("outputs_before_reset", 64'(outs_this_job >= reset_after), 64'd1);
            mid_reset();
            return;
        end
        chk("job_completed", 64'(job_complete), 64'd1);
        chk("ctrl_start_count", 64'(starts_this_job), 64'd1);
        chk("outputs_count", 64'(outs_this_job), 64'(NWORDS));
        chk("out_queue_drained", 64'(out_exp.size()), 64'd0);
        chk("write_queue_drained", 64'(wr_exp.size()), 64'd0);
        chk("ctrl_mod_idx_held", 64'(ctrl_mod_idx), 64'(mod));
        if (stall == 0)
            chk("throughput", 64'(last_hs_cyc - first_out_cyc), 64'(NWORDS - 1));
        repeat (2) @(negedge clk);
    endtask

    initial begin : main
        in_reset    = 1'b1;
        reset       = 1'b1;
        job_start   = 1'b0;
        job_mod_idx = '0;
        in_valid    = 1'b0;
        in_data     = '0;
        glitch_en   = 1'b0;
        stall_pct   = 0;
        jd_pending  = 1'b0;
        last_wr_cyc = 0;
        repeat (2) @(posedge clk);
        #2;
        check_idle("reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        in_reset = 1'b0;

        run_job(6'd5, 0, 0, 1'b0, 0, 1'b0, 1'b1);
        run_job(6'($urandom), 1, 30, 1'b0, 0, 1'b0, 1'b0);
        run_job(6'($urandom), 2, 30, 1'b1, 0, 1'b1, 1'b0);
        run_job(6'($urandom), 0, 0, 1'b0, 5, 1'b0, 1'b0);
        run_job(6'($urandom), 0, 0, 1'b0, 0, 1'b0, 1'b0);
        for (int j = 0; j < 3; j++)
            run_job(6'($urandom), 2, 30, 1'b0, 0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish cycle=%0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
